alarm_sequencer: RTL and testbench

Controls the alarm's ring lifecycle: arming, ringing, snooze and stop.
- Watches the seconds-of-day time base (sec_cnt) and the programmed alarm time (alm_cnt, supplied by the alarm-time register block).
- Drives the buzzer through a ring/snooze/timeout state machine.
- Sits between the clock counter, the alarm-time register block and the buzzer/LED outputs.

---
 rtl/alarm_sequencer.sv | 132 +++++++++++++
 tb/tb_alarm_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Alarm ring lifecycle: IDLE -> ARMED -> RINGING <-> SNOOZE, with ring timeout and snooze limit.
// Optional macro ALARM_PATTERN_EN: buzzer beeps 1 s on / 1 s off instead of sounding continuously.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk_out,
  input  logic        reset,
  input  logic        alm,
  input  logic [16:0] sec_cnt,
  input  logic [16:0] alm_cnt,
  input  logic        snooze,
  input  logic        stop,
  output logic        buzz,
  output logic        ringing,
  output logic        snoozing,
  output logic [2:0]  snooze_left,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  localparam logic [16:0] SEC_PER_DAY = 17'd86400;
  localparam logic [7:0]  RING_LAST   = 8'(RING_SECS - 1);
  localparam logic [2:0]  SNZ_MAX     = 3'(MAX_SNOOZE);
  localparam logic [17:0] SNZ_DELAY   = 18'(SNOOZE_SECS);

  state_e      state_q;
  logic [2:0]  snooze_left_q;
  logic [7:0]  ring_cnt_q;
  logic [16:0] snz_target_q;
  logic [16:0] sec_prev_q;
  logic        snooze_prev_q;
  logic        stop_prev_q;

  logic        tick;
  logic        snz_edge;
  logic        stp_edge;
  logic        alm_match;
  logic        snz_match;
  logic [17:0] snz_sum;
  logic [16:0] snz_target_d;

  assign tick     = (sec_cnt != sec_prev_q);
  assign snz_edge = snooze & ~snooze_prev_q;
  assign stp_edge = stop & ~stop_prev_q;

  // Out-of-range alarm times must never ring, even if sec_cnt is driven out of range.
  assign alm_match = tick && (alm_cnt < SEC_PER_DAY) && (sec_cnt == alm_cnt);
  assign snz_match = tick && (sec_cnt == snz_target_q);

  // Snooze target wraps across midnight; the sum fits in 18 bits for legal parameters.
  assign snz_sum      = {1'b0, sec_cnt} + SNZ_DELAY;
  assign snz_target_d = (snz_sum >= {1'b0, SEC_PER_DAY}) ? 17'(snz_sum - {1'b0, SEC_PER_DAY})
                                                          : snz_sum[16:0];

  always_ff @(posedge clk_out) begin
    if (reset) begin
      state_q       <= IDLE;
      snooze_left_q <= SNZ_MAX;
      ring_cnt_q    <= '0;
      snz_target_q  <= '0;
      sec_prev_q    <= sec_cnt;
      snooze_prev_q <= 1'b0;
      stop_prev_q   <= 1'b0;
    end else begin
      sec_prev_q    <= sec_cnt;
      snooze_prev_q <= snooze;
      stop_prev_q   <= stop;
      if (!alm) begin
        state_q       <= IDLE;
        snooze_left_q <= SNZ_MAX;
      end else begin
        case (state_q)
          IDLE: state_q <= ARMED;
          ARMED: begin
            if (alm_match) begin
              state_q    <= RINGING;
              ring_cnt_q <= '0;
            end
          end
          RINGING: begin
            if (stp_edge) begin
              state_q       <= ARMED;
              snooze_left_q <= SNZ_MAX;
            end else if (snz_edge && snooze_left_q != 3'd0) begin
              state_q       <= SNOOZE;
              snooze_left_q <= snooze_left_q - 3'd1;
              snz_target_q  <= snz_target_d;
            end else if (tick) begin
              // Timeout counts ticks, so a ring spanning midnight still lasts RING_SECS.
              if (ring_cnt_q == RING_LAST) begin
                state_q       <= ARMED;
                snooze_left_q <= SNZ_MAX;
              end else begin
                ring_cnt_q <= ring_cnt_q + 8'd1;
              end
            end
          end
          SNOOZE: begin
            if (stp_edge) begin
              state_q       <= ARMED;
              snooze_left_q <= SNZ_MAX;
            end else if (snz_match) begin
              state_q    <= RINGING;
              ring_cnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign ringing     = (state_q == RINGING);
  assign snoozing    = (state_q == SNOOZE);
  assign snooze_left = snooze_left_q;

`ifdef ALARM_PATTERN_EN
  assign buzz = ringing && (ring_cnt_q[0] == 1'b0);
`else
  assign buzz = ringing;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default parameters (60 s ring, 300 s snooze, 3 snoozes).
module tb_alarm_sequencer;

  logic        clk_out = 1'b0;
  logic        reset, alm, snooze, stop;
  logic [16:0] sec_cnt, alm_cnt;
  logic        buzz, ringing, snoozing;
  logic [2:0]  snooze_left;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  alarm_sequencer dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .alm        (alm),
    .sec_cnt    (sec_cnt),
    .alm_cnt    (alm_cnt),
    .snooze     (snooze),
    .stop       (stop),
    .buzz       (buzz),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_left(snooze_left),
    .state      (state)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic set_sec(input int v);
    sec_cnt = 17'(v);
    step();
  endtask

  task automatic press_snooze();
    snooze = 1'b1; step();
  endtask

  task automatic release_btns();
    snooze = 1'b0; stop = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; alm = 1'b0; snooze = 1'b0; stop = 1'b0;
    sec_cnt = 17'd25198; alm_cnt = 17'd25200;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_left", snooze_left, 3);
    chk("rst_buzz", buzz, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    reset = 1'b0;
    step();
    chk("idle_no_alm", state, 0);

    // Arm and match
    alm = 1'b1; step();
    chk("armed", state, 1);
    set_sec(25199);
    chk("armed_pre", state, 1);
    set_sec(25200);
    chk("ring_state", state, 2);
    chk("ring_buzz", buzz, 1);
    chk("ring_ringing", ringing, 1);

    // Timeout after 60 ticks
    for (int i = 1; i < 60; i++) set_sec(25200 + i);
    chk("ring_59_ticks", state, 2);
    set_sec(25260);
    chk("timeout_state", state, 1);
    chk("timeout_buzz", buzz, 0);
    chk("timeout_left", snooze_left, 3);
    step(); step();
    chk("no_rering", state, 1);
    // Alarm time set to current time without a tick must not ring
    alm_cnt = 17'd25260; step(); step();
    chk("match_no_tick", state, 1);

    // Snooze across midnight and snooze limit
    alm_cnt = 17'd86350;
    set_sec(86349);
    set_sec(86350);
    chk("ring2_state", state, 2);
    press_snooze();
    chk("snz1_state", state, 3);
    chk("snz1_left", snooze_left, 2);
    chk("snz1_snoozing", snoozing, 1);
    chk("snz1_buzz", buzz, 0);
    release_btns();
    set_sec(86399);
    set_sec(0);
    chk("snz_wrap", state, 3);
    set_sec(249);
    chk("snz_249", state, 3);
    set_sec(250);
    chk("snz_target_250", state, 2);
    press_snooze();
    chk("snz2_left", snooze_left, 1);
    release_btns();
    set_sec(550);
    chk("snz2_ring", state, 2);
    press_snooze();
    chk("snz3_left", snooze_left, 0);
    chk("snz3_state", state, 3);
    release_btns();
    set_sec(850);
    chk("snz3_ring", state, 2);
    press_snooze();
    chk("snz4_ignored", state, 2);
    chk("snz4_left", snooze_left, 0);
    release_btns();

    // Stop and snooze together: stop wins
    snooze = 1'b1; stop = 1'b1; step();
    chk("both_state", state, 1);
    chk("both_left", snooze_left, 3);
    release_btns();

    // Snooze ignored in SNOOZE, stop from SNOOZE
    alm_cnt = 17'd900;
    set_sec(900);
    chk("ring3_state", state, 2);
    press_snooze();
    release_btns();
    press_snooze();
    chk("snz_in_snz", state, 3);
    chk("snz_in_snz_left", snooze_left, 2);
    release_btns();
    stop = 1'b1; step();
    chk("stop_snz_state", state, 1);
    chk("stop_snz_left", snooze_left, 3);
    release_btns();

    // alm=0 while ringing
    alm_cnt = 17'd1000;
    set_sec(1000);
    chk("ring4_state", state, 2);
    alm = 1'b0; step();
    chk("disable_state", state, 0);
    chk("disable_buzz", buzz, 0);
    alm = 1'b1; step();
    chk("rearm", state, 1);

    // Reset mid-snooze cancels the pending re-ring
    alm_cnt = 17'd1100;
    set_sec(1100);
    press_snooze();
    release_btns();
    chk("snz5_state", state, 3);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("rst_mid_state", state, 0);
    chk("rst_mid_left", snooze_left, 3);
    step();
    chk("rst_mid_armed", state, 1);
    set_sec(1400);
    chk("rst_no_snz_ring", state, 1);

    // Buzz pattern over the first 6 ring seconds
    alm_cnt = 17'd2000;
    set_sec(2000);
    for (int i = 0; i < 6; i++) begin
`ifdef ALARM_PATTERN_EN
      chk($sformatf("pattern_%0d", i), buzz, (i % 2 == 0) ? 1 : 0);
`else
      chk($sformatf("pattern_%0d", i), buzz, 1);
`endif
      set_sec(2001 + i);
    end
    chk("pattern_still_ring", state, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
